// File: rtl/ysyx_23060124_lsu_axi_pkg.sv
// Shared constants for the LSU AXI4-Lite master: access sizes, AXI response
// codes and FSM state encodings.
package ysyx_23060124_lsu_axi_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // FSM states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_D = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_WR_B = 3'd4;
    localparam logic [2:0] ST_RESP = 3'd5;

endpackage

// File: rtl/ysyx_23060124_lsu_align.sv
// Combinational lane logic for the LSU AXI master: store data/strobe lane
// placement, load lane extraction with sign/zero extension, and the
// alignment check. Only a 32-bit data path is supported.
module ysyx_23060124_lsu_align
    import ysyx_23060124_lsu_axi_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] ld_data,
    output logic              misaligned
);

    logic [4:0]        lane_sh;
    logic [DATA_W-1:0] rd_shifted;

    assign lane_sh = {off, 3'b000};

    // Place store data in its byte lanes and build the matching strobe
    always_comb begin
        bus_wdata = st_data << lane_sh;
        bus_wstrb = 4'b0000;
        case (size)
            SIZE_B:  bus_wstrb = 4'b0001 << off;
            SIZE_H:  bus_wstrb = 4'b0011 << off;
            SIZE_W:  bus_wstrb = 4'b1111;
            default: bus_wstrb = 4'b0000;
        endcase
    end

    // Pull the addressed lanes down to bit 0 and extend to full width
    always_comb begin
        rd_shifted = bus_rdata >> lane_sh;
        ld_data    = rd_shifted;
        case (size)
            SIZE_B:  ld_data = {{(DATA_W-8){sext & rd_shifted[7]}}, rd_shifted[7:0]};
            SIZE_H:  ld_data = {{(DATA_W-16){sext & rd_shifted[15]}}, rd_shifted[15:0]};
            default: ld_data = rd_shifted;
        endcase
    end

    // Size 3 is treated as misaligned so it never reaches the bus
    always_comb begin
        case (size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = off[0];
            SIZE_W:  misaligned = |off;
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_23060124_lsu_axi.sv
// LSU memory-side stage: runs one load or store per transaction as an
// AXI4-Lite master and returns a single response.
// Optional bus watchdog enabled by defining YSYX_23060124_LSU_TIMEOUT_EN.
module ysyx_23060124_lsu_axi
    import ysyx_23060124_lsu_axi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic [1:0]        al_off, al_size;
    logic [DATA_W-1:0] al_wdata, al_ldata;
    logic [3:0]        al_wstrb;
    logic              al_misaligned;
    logic              aw_now, w_now;

    // In IDLE the incoming request is checked; afterwards the latched copy drives the lanes
    assign al_off  = (state_q == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign al_size = (state_q == ST_IDLE) ? req_size : size_q;

    ysyx_23060124_lsu_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .off       (al_off),
        .size      (al_size),
        .sext      (sext_q),
        .st_data   (wdata_q),
        .bus_wdata (al_wdata),
        .bus_wstrb (al_wstrb),
        .bus_rdata (rdata),
        .ld_data   (al_ldata),
        .misaligned(al_misaligned)
    );

    assign aw_now = aw_done_q | awready;
    assign w_now  = w_done_q | wready;

`ifdef YSYX_23060124_LSU_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        bus_wait;

    assign bus_wait = (state_q == ST_RD_A) || (state_q == ST_RD_D) ||
                      (state_q == ST_WR) || (state_q == ST_WR_B);
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // Next-state and datapath latching
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        sext_d    = sext_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    size_d    = req_size;
                    sext_d    = req_sext;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (al_misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = req_wen ? ST_WR : ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                if (arready) state_d = ST_RD_D;
            end
            ST_RD_D: begin
                if (rvalid) begin
                    rdata_d = al_ldata;
                    err_d   = (rresp != RESP_OKAY);
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                // Address and data channels may complete in any order
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (bvalid) begin
                    err_d   = (bresp != RESP_OKAY);
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef YSYX_23060124_LSU_TIMEOUT_EN
        cnt_d = '0;
        if (bus_wait && (state_d == state_q)) begin
            if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                state_d   = ST_RESP;
                err_d     = 1'b1;
                rdata_d   = '0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            sext_q    <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef YSYX_23060124_LSU_TIMEOUT_EN
    // Watchdog counter, restarted on every state change
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    // Bus and response outputs are pure decodes of state, so reset clears them at once
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign araddr     = {addr_q[ADDR_W-1:2], 2'b00};
    assign arvalid    = (state_q == ST_RD_A);
    assign rready     = (state_q == ST_RD_D);
    assign awaddr     = {addr_q[ADDR_W-1:2], 2'b00};
    assign awvalid    = (state_q == ST_WR) && !aw_done_q;
    assign wvalid     = (state_q == ST_WR) && !w_done_q;
    assign wdata      = al_wdata;
    assign wstrb      = al_wstrb;
    assign bready     = (state_q == ST_WR_B);

endmodule

// File: tb/tb_ysyx_23060124_lsu_axi.sv
// Testbench for ysyx_23060124_lsu_axi: directed and randomized loads/stores
// against an arithmetic reference model, with the bench acting as AXI slave.
module tb_ysyx_23060124_lsu_axi;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen, req_sext;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_23060124_lsu_axi #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(1024)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: extract the addressed bytes and extend them
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [1:0] size, input logic sext);
        longint unsigned v, mask;
        int nb;
        nb   = 1 << size;
        v    = longint'(rd) >> (8 * off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (sext && nb < 4 && v[8*nb-1]) v = v | (~mask & 64'hFFFF_FFFF);
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] off, input logic [1:0] size);
        int s;
        s = ((1 << (1 << size)) - 1) << off;
        return s[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] off);
        logic [63:0] t;
        t = {32'd0, wd} << (8 * off);
        return t[31:0];
    endfunction

    function automatic bit model_bad(input logic [31:0] addr, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    // Hold the response for some cycles, then accept it
    task automatic finish_resp(input logic [31:0] exp_d, input logic exp_e, input int hold);
        resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk("resp_valid_hold", resp_valid, 1);
            chk("resp_rdata_hold", resp_rdata, exp_d);
            chk("resp_err_hold", resp_err, exp_e);
            @(negedge clock);
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_rdata", resp_rdata, exp_d);
        chk("resp_err", resp_err, exp_e);
        chk("req_ready_in_resp", req_ready, 0);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk("resp_valid_drop", resp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic sext, input logic [31:0] wd);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_size  = size;
        req_sext  = sext;
        req_wdata = wd;
        chk("req_ready_idle", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        req_wdata = $urandom;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic sext,
                           input logic [31:0] rd, input logic [1:0] rr, input int ar_wait,
                           input int r_wait, input int hold);
        issue(1'b0, addr, size, sext, $urandom);
        for (int i = 0; i < ar_wait; i++) begin
            chk("arvalid_wait", arvalid, 1);
            @(negedge clock);
        end
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, addr & 32'hFFFF_FFFC);
        chk("awvalid_on_load", awvalid, 0);
        chk("req_ready_busy", req_ready, 0);
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 0);
        for (int i = 0; i < r_wait; i++) begin
            chk("rready_wait", rready, 1);
            @(negedge clock);
        end
        chk("rready", rready, 1);
        chk("resp_valid_early", resp_valid, 0);
        rvalid = 1'b1;
        rdata  = rd;
        rresp  = rr;
        @(negedge clock);
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'd0;
        chk("rready_drop", rready, 0);
        finish_resp(model_load(rd, addr[1:0], size, sext), rr != 2'd0, hold);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                            input logic [1:0] br, input int aw_d, input int w_d, input int b_wait,
                            input int hold);
        int last;
        last = (aw_d > w_d) ? aw_d : w_d;
        issue(1'b1, addr, size, 1'b0, wd);
        chk("arvalid_on_store", arvalid, 0);
        for (int k = 0; k <= last; k++) begin
            chk("awvalid", awvalid, (k <= aw_d) ? 1 : 0);
            chk("wvalid", wvalid, (k <= w_d) ? 1 : 0);
            if (k <= aw_d) chk("awaddr", awaddr, addr & 32'hFFFF_FFFC);
            if (k <= w_d) begin
                chk("wdata", wdata, model_wdata(wd, addr[1:0]));
                chk("wstrb", wstrb, model_strb(addr[1:0], size));
            end
            awready = (k == aw_d);
            wready  = (k == w_d);
            @(negedge clock);
        end
        awready = 1'b0;
        wready  = 1'b0;
        chk("awvalid_done", awvalid, 0);
        chk("wvalid_done", wvalid, 0);
        for (int i = 0; i < b_wait; i++) begin
            chk("bready_wait", bready, 1);
            chk("resp_valid_early_b", resp_valid, 0);
            @(negedge clock);
        end
        chk("bready", bready, 1);
        bvalid = 1'b1;
        bresp  = br;
        @(negedge clock);
        bvalid = 1'b0;
        bresp  = 2'd0;
        chk("bready_drop", bready, 0);
        finish_resp(32'd0, br != 2'd0, hold);
    endtask

    task automatic do_bad(input logic wen, input logic [31:0] addr, input logic [1:0] size);
        issue(wen, addr, size, 1'b1, $urandom);
        chk("bad_arvalid", arvalid, 0);
        chk("bad_awvalid", awvalid, 0);
        chk("bad_wvalid", wvalid, 0);
        finish_resp(32'd0, 1'b1, 0);
    endtask

    logic [31:0] r_addr, r_val;
    logic [1:0]  r_size, r_code;
    logic        r_sext;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_size   = '0;
        req_sext   = 1'b0;
        resp_ready = 1'b0;
        arready    = 1'b0;
        rdata      = '0;
        rresp      = '0;
        rvalid     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bresp      = '0;
        bvalid     = 1'b0;

        // Reset values
        @(negedge clock);
        @(negedge clock);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_araddr", araddr, 0);
        rst_n = 1'b1;
        @(negedge clock);

        // Signed byte load from the top lane, zero-wait slave
        do_load(32'h8000_0003, 2'd0, 1'b1, 32'h8100_0000, 2'd0, 0, 0, 0);
        // Store half to upper lanes: awready before wready, then both together
        do_store(32'h8000_0002, 2'd1, 32'h0000_ABCD, 2'd0, 0, 2, 0, 0);
        do_store(32'h8000_0002, 2'd1, 32'h0000_ABCD, 2'd0, 0, 0, 0, 0);
        // wready before awready
        do_store(32'h8000_0001, 2'd0, 32'h1234_5678, 2'd0, 3, 1, 1, 0);
        // Misaligned word load and illegal size
        do_bad(1'b0, 32'h8000_0001, 2'd2);
        do_bad(1'b1, 32'h8000_0004, 2'd3);
        // SLVERR on read, response held through backpressure
        do_load(32'h8000_0002, 2'd1, 1'b0, 32'hBEEF_1234, 2'd2, 1, 2, 4);
        // DECERR on write
        do_store(32'h8000_0010, 2'd2, 32'hCAFE_F00D, 2'd3, 1, 1, 2, 1);

        // Asynchronous reset while waiting for read data
        issue(1'b0, 32'h8000_0020, 2'd2, 1'b0, 32'd0);
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        chk("mid_rready", rready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rready", rready, 0);
        chk("async_arvalid", arvalid, 0);
        chk("async_resp_valid", resp_valid, 0);
        chk("async_resp_rdata", resp_rdata, 0);
        chk("async_resp_err", resp_err, 0);
        chk("async_req_ready", req_ready, 1);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        do_load(32'h8000_0020, 2'd2, 1'b0, 32'h0BAD_F00D, 2'd0, 0, 0, 0);

        // Randomized mix against the model
        for (int i = 0; i < 60; i++) begin
            r_val  = $urandom;
            r_addr = {16'h8000, r_val[15:0]};
            r_size = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) r_size = 2'd3;
            if ($urandom_range(0, 4) != 0) begin
                if (r_size == 2'd1) r_addr[0] = 1'b0;
                if (r_size == 2'd2) r_addr[1:0] = 2'd0;
            end
            r_sext = 1'($urandom_range(0, 1));
            r_code = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 2'd2 : 2'd3)
                                                 : 2'd0;
            r_val  = $urandom;
            if (model_bad(r_addr, r_size)) begin
                do_bad(1'($urandom_range(0, 1)), r_addr, r_size);
            end else if ($urandom_range(0, 1) == 1) begin
                do_load(r_addr, r_size, r_sext, r_val, r_code, $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                do_store(r_addr, r_size, r_val, r_code, $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
